fisr_seed_stage: RTL and testbench

Front-end stage of the fast inverse square root datapath, directly upstream of the Newton iteration stage. Accepts a raw IEEE-754 single-precision operand x and produces the two Newton operands: x/2 and the integer magic-number seed y0 = 0x5F3759DF − (x >> 1). Operands the Newton stage cannot handle (zero, denormal, negative, Inf, NaN) are classified here. Their IEEE-correct results travel on a delay line aligned to the Newton stage's output.

---
 rtl/fisr_seed_stage.sv | 135 +++++++++++++
 tb/tb_fisr_seed_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fisr_seed_stage.sv
// Fast inverse square root front end: classifies x, produces x/2 and the magic seed,
// and carries IEEE results for special operands on a delay line aligned to the Newton output.
module fisr_seed_stage #(
    parameter int          NEWTON_LAT = 6,
    parameter logic [31:0] MAGIC      = 32'h5F3759DF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Data_in,
    input  logic        Data_in_valid,
    output logic [31:0] Data_out1,
    output logic [31:0] Data_out2,
    output logic        Valid,
    output logic        Special_flag,
    output logic [31:0] Special_data,
    output logic        Special_valid
);

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NORM = 3'd1,
        CLS_NEG  = 3'd2,
        CLS_PINF = 3'd3,
        CLS_NAN  = 3'd4
    } cls_t;

    localparam int DL_W = 34;

    cls_t        w_in_class;
    logic [31:0] w_half;
    logic [31:0] w_seed;
    logic [31:0] w_out1;
    logic [31:0] w_out2;
    logic        w_flag;
    logic [31:0] w_sdata;

    logic        r_s1_valid;
    logic [31:0] r_s1_data;
    cls_t        r_s1_class;

    logic [31:0] r_out1;
    logic [31:0] r_out2;
    logic        r_valid;
    logic        r_flag;
    logic [31:0] r_sdata;

    logic [DL_W-1:0] r_dl [NEWTON_LAT];

    // Denormals share the zero class; NaN wins over sign, -Inf counts as negative.
    always_comb begin
        w_in_class = CLS_NORM;
        if (Data_in[30:23] == 8'h00)
            w_in_class = CLS_ZERO;
        else if (Data_in[30:23] == 8'hFF && Data_in[22:0] != 23'd0)
            w_in_class = CLS_NAN;
        else if (Data_in[31])
            w_in_class = CLS_NEG;
        else if (Data_in[30:23] == 8'hFF)
            w_in_class = CLS_PINF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 32'd0;
            r_s1_class <= CLS_ZERO;
        end else begin
            r_s1_valid <= Data_in_valid;
            r_s1_data  <= Data_in;
            r_s1_class <= w_in_class;
        end
    end

    // Halving exponent 1 drops into the denormal range: hidden bit shifts into the mantissa.
    assign w_half = (r_s1_data[30:23] == 8'd1) ?
                    {9'd0, 1'b1, r_s1_data[22:1]} :
                    {1'b0, r_s1_data[30:23] - 8'd1, r_s1_data[22:0]};
    assign w_seed = MAGIC - {1'b0, r_s1_data[31:1]};

    always_comb begin
        w_out1  = 32'd0;
        w_out2  = 32'd0;
        w_flag  = 1'b1;
        w_sdata = 32'h7FC00000;
        case (r_s1_class)
            CLS_NORM: begin
                w_out1  = w_half;
                w_out2  = w_seed;
                w_flag  = 1'b0;
                w_sdata = 32'd0;
            end
            CLS_ZERO: w_sdata = r_s1_data[31] ? 32'hFF800000 : 32'h7F800000;
            CLS_PINF: w_sdata = 32'd0;
            default:  w_sdata = 32'h7FC00000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out1  <= 32'd0;
            r_out2  <= 32'd0;
            r_flag  <= 1'b0;
            r_sdata <= 32'd0;
        end else begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out1  <= w_out1;
                r_out2  <= w_out2;
                r_flag  <= w_flag;
                r_sdata <= w_sdata;
            end
        end
    end

    // Entry 0 is one cycle behind S2; the tail lines up with the Newton stage's Valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NEWTON_LAT; i++)
                r_dl[i] <= '0;
        end else begin
            r_dl[0] <= {r_valid, r_flag, r_sdata};
            for (int i = 1; i < NEWTON_LAT; i++)
                r_dl[i] <= r_dl[i-1];
        end
    end

    assign Data_out1     = r_out1;
    assign Data_out2     = r_out2;
    assign Valid         = r_valid;
    assign Special_valid = r_dl[NEWTON_LAT-1][33];
    assign Special_flag  = r_dl[NEWTON_LAT-1][32];
    assign Special_data  = r_dl[NEWTON_LAT-1][31:0];

endmodule

// File: tb/tb_fisr_seed_stage.sv
// Self-checking bench for fisr_seed_stage: directed scenarios plus a randomized
// stream of positive normals scored against an arithmetic reference model.
module tb_fisr_seed_stage;

    localparam int          NL    = 6;
    localparam logic [31:0] MAGIC = 32'h5F3759DF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Data_in = 32'd0;
    logic        Data_in_valid = 1'b0;
    logic [31:0] Data_out1;
    logic [31:0] Data_out2;
    logic        Valid;
    logic        Special_flag;
    logic [31:0] Special_data;
    logic        Special_valid;

    int checks = 0;
    int errors = 0;

    logic        st_v [$];
    logic [31:0] st_d [$];

    fisr_seed_stage #(.NEWTON_LAT(NL), .MAGIC(MAGIC)) dut (
        .clk          (clk),
        .rst          (rst),
        .Data_in      (Data_in),
        .Data_in_valid(Data_in_valid),
        .Data_out1    (Data_out1),
        .Data_out2    (Data_out2),
        .Valid        (Valid),
        .Special_flag (Special_flag),
        .Special_data (Special_data),
        .Special_valid(Special_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit ref_is_special(input logic [31:0] x);
        return (x[30:23] == 8'd0) || (x[30:23] == 8'd255) || x[31];
    endfunction

    function automatic logic [31:0] ref_special(input logic [31:0] x);
        if (x[30:23] == 8'd0)                         return x[31] ? 32'hFF800000 : 32'h7F800000;
        if (x[30:23] == 8'd255 && x[22:0] != 23'd0)  return 32'h7FC00000;
        if (x[31])                                    return 32'h7FC00000;
        if (x[30:23] == 8'd255)                       return 32'h00000000;
        return 32'h00000000;
    endfunction

    // x = sig * 2^(e-150); x/2 = sig * 2^(e-151). Below the normal range the
    // denormal mantissa is the value in units of 2^-149, truncated.
    function automatic logic [31:0] ref_half(input logic [31:0] x);
        int e;
        longint sig;
        longint dm;
        if (ref_is_special(x)) return 32'd0;
        e   = int'(x[30:23]);
        sig = longint'(x[22:0]) + (longint'(1) << 23);
        if (e - 1 >= 1) return {1'b0, 8'(e - 1), x[22:0]};
        dm = sig >> (2 - e);
        return {9'd0, dm[22:0]};
    endfunction

    function automatic logic [31:0] ref_seed(input logic [31:0] x);
        if (ref_is_special(x)) return 32'd0;
        return MAGIC - (x >> 1);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        Data_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: replays st_v/st_d one per cycle from a fresh reset, checking every cycle.
    task automatic play_stream(input string tag);
        int n;
        int k;
        logic [31:0] hold1;
        logic [31:0] hold2;
        logic ev;
        logic esv;
        n = st_v.size();
        hold1 = 32'd0;
        hold2 = 32'd0;
        do_reset();
        for (int c = 0; c < n + 3 + NL; c++) begin
            if (c < n) begin
                Data_in_valid = st_v[c];
                Data_in = st_d[c];
            end else begin
                Data_in_valid = 1'b0;
                Data_in = $urandom;
            end
            tick();
            k = c - 1;
            ev = (k >= 0 && k < n) ? st_v[k] : 1'b0;
            if (ev) begin
                hold1 = ref_half(st_d[k]);
                hold2 = ref_seed(st_d[k]);
            end
            checks++;
            if (Valid !== ev) begin
                errors++;
                $display("FAIL %s valid cyc=%0d got=%b exp=%b", tag, c + 1, Valid, ev);
            end
            checks++;
            if (Data_out1 !== hold1) begin
                errors++;
                $display("FAIL %s out1 cyc=%0d got=%h exp=%h", tag, c + 1, Data_out1, hold1);
            end
            checks++;
            if (Data_out2 !== hold2) begin
                errors++;
                $display("FAIL %s out2 cyc=%0d got=%h exp=%h", tag, c + 1, Data_out2, hold2);
            end
            k = c - 1 - NL;
            esv = (k >= 0 && k < n) ? st_v[k] : 1'b0;
            checks++;
            if (Special_valid !== esv) begin
                errors++;
                $display("FAIL %s special_valid cyc=%0d got=%b exp=%b", tag, c + 1, Special_valid, esv);
            end
            if (esv) begin
                checks++;
                if (Special_flag !== ref_is_special(st_d[k])) begin
                    errors++;
                    $display("FAIL %s special_flag cyc=%0d got=%b exp=%b", tag, c + 1,
                             Special_flag, ref_is_special(st_d[k]));
                end
                checks++;
                if (Special_data !== ref_special(st_d[k])) begin
                    errors++;
                    $display("FAIL %s special_data cyc=%0d got=%h exp=%h", tag, c + 1,
                             Special_data, ref_special(st_d[k]));
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        Data_in_valid = 1'b1;
        Data_in = 32'h40800000;
        for (int i = 0; i < NL + 3; i++) tick();
        checks++;
        if ({Data_out1, Data_out2, Valid, Special_flag, Special_data, Special_valid} !== 99'd0) begin
            errors++;
            $display("FAIL reset_values out1=%h out2=%h v=%b sf=%b sd=%h sv=%b", Data_out1, Data_out2,
                     Valid, Special_flag, Special_data, Special_valid);
        end
        rst = 1'b0;
        Data_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid_ignored cyc=%0d got=%b exp=0", i, Valid);
            end
        end
    endtask

    task automatic test_single();
        st_v = {1'b1};
        st_d = {32'h40800000};
        play_stream("single_4p0");
    endtask

    task automatic test_back_to_back();
        st_v = {1'b1, 1'b1};
        st_d = {32'h3F800000, 32'h00C00000};
        play_stream("back_to_back");
    endtask

    task automatic test_specials();
        st_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        st_d = {32'h00000000, 32'h80000000, 32'hC0000000, 32'h7F800000,
                32'h7FC00001, 32'h00012345, 32'h80000001, 32'hFF800000};
        play_stream("specials");
    endtask

    task automatic test_gap();
        st_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        st_d = {32'h41200000, 32'h3F800000, 32'h00800000, 32'h7F7FFFFF, 32'h12345678, 32'h00FFFFFF};
        play_stream("gap");
    endtask

    task automatic test_reset_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            Data_in_valid = 1'b1;
            Data_in = (i == 1) ? 32'h00000000 : 32'h40800000;
            tick();
        end
        rst = 1'b1;
        Data_in = 32'h7F800000;
        tick();
        rst = 1'b0;
        Data_in_valid = 1'b0;
        checks++;
        if ({Data_out1, Data_out2, Valid, Special_flag, Special_data, Special_valid} !== 99'd0) begin
            errors++;
            $display("FAIL flush_outputs out1=%h out2=%h v=%b sf=%b sd=%h sv=%b", Data_out1, Data_out2,
                     Valid, Special_flag, Special_data, Special_valid);
        end
        for (int i = 0; i < NL + 3; i++) begin
            tick();
            checks++;
            if (Valid !== 1'b0 || Special_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_pulse cyc=%0d valid=%b special_valid=%b exp=0,0", i, Valid,
                         Special_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] e;
        st_v.delete();
        st_d.delete();
        for (int i = 0; i < 10000; i++) begin
            e = ($urandom_range(0, 7) == 0) ? 8'(($urandom_range(0, 1) == 0) ? 1 : 2)
                                             : 8'($urandom_range(1, 254));
            st_v.push_back($urandom_range(0, 9) != 0);
            st_d.push_back({1'b0, e, 23'($urandom)});
        end
        play_stream("random_norm");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_specials();
        test_gap();
        test_reset_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
